data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/dmem_pkg.sv | 11 +
 rtl/data_memory.sv | 66 ++++++
 tb/tb_data_memory.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared sizing for the data memory: word width, depth, byte-offset bits and word-index width.
package dmem_pkg;

  localparam int XLEN     = 64;
  localparam int DEPTH    = 128;
  localparam int ADDR_LSB = $clog2(XLEN / 8);
  localparam int IDX_W    = $clog2(DEPTH);

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: 1-edge write, combinational read, async clear; no handshake, never stalls.
// DATA_MEMORY_RANGE_CHECK_EN drops/zeroes accesses at or above DEPTH words instead of wrapping.
module data_memory
  import dmem_pkg::*;
#(
  parameter int XLEN  = dmem_pkg::XLEN,
  parameter int DEPTH = dmem_pkg::DEPTH
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  input  logic            write_en,
  input  logic            read_en,
  output logic [XLEN-1:0] read_data
);

  localparam int LSB  = $clog2(XLEN / 8);
  localparam int IW   = $clog2(DEPTH);
  localparam int HI   = LSB + IW;

  logic [XLEN-1:0] mem [DEPTH];
  logic [IW-1:0]   idx;
  logic            oor;

  assign idx = address[LSB +: IW];

`ifdef DATA_MEMORY_RANGE_CHECK_EN
  // Any set bit above the index field means the byte address is past the last word.
  if (XLEN > HI) begin : g_hi
    assign oor = |address[XLEN-1:HI];
  end else begin : g_nohi
    assign oor = 1'b0;
  end

  always @(posedge clk) begin
    if (rstn && write_en && oor)
      $error("data_memory: out-of-range write to address %h dropped", address);
    if (rstn && read_en && oor)
      $error("data_memory: out-of-range read from address %h returns zero", address);
  end
`else
  assign oor = 1'b0;
`endif

  // Byte-offset bits (and, when wrapping, the upper bits) never select a word.
  if (XLEN > HI) begin : g_unused_hi
    logic unused_addr;
    assign unused_addr = ^{address[LSB-1:0], address[XLEN-1:HI]};
  end else begin : g_unused_lo
    logic unused_addr;
    assign unused_addr = ^address[LSB-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_en && !oor) begin
      mem[idx] <= write_data;
    end
  end

  // No write bypass: a same-cycle write only shows up once the edge has updated the array.
  assign read_data = (rstn && read_en && !oor) ? mem[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset behaviour, fill/readback, vector table, async clear, address wrap.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        write_en;
  logic        read_en;
  logic [63:0] read_data;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory dut (
    .clk        (clk),
    .rstn       (rstn),
    .address    (address),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_pre;
    logic [63:0] exp_post;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Memory state going into the table: word n = 3n+1.
    vecs[0] = '{"wr_rd_same_word",  1'b1, 1'b1, 64'd16,    64'hA5,                 64'd7,                  64'hA5};
    vecs[1] = '{"misaligned_read",  1'b0, 1'b1, 64'd19,    64'h0,                  64'hA5,                 64'hA5};
    vecs[2] = '{"read_en_low",      1'b0, 1'b0, 64'd19,    64'h0,                  64'h0,                  64'h0};
    vecs[3] = '{"write_no_read",    1'b1, 1'b0, 64'd24,    64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 64'h0};
    vecs[4] = '{"read_all_ones",    1'b0, 1'b1, 64'd31,    64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{"last_word_wr",     1'b1, 1'b1, 64'h3F8,   64'h1234,               64'h17E,                64'h1234};
    vecs[6] = '{"last_word_top",    1'b0, 1'b1, 64'h3FF,   64'h0,                  64'h1234,               64'h1234};
    vecs[7] = '{"word0_misaligned", 1'b1, 1'b1, 64'd5,     64'hDEAD_BEEF_0000_0001, 64'd1,                 64'hDEAD_BEEF_0000_0001};
    vecs[8] = '{"word1_untouched",  1'b0, 1'b1, 64'd8,     64'h0,                  64'd4,                  64'd4};

    // Reset held: a write attempt is ignored and reads give zero.
    rstn = 1'b0; write_en = 1'b1; address = 64'd8; write_data = 64'd5; read_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_read_addr8", read_data, 64'd0);
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      write_en = 1'b0; address = 64'(8 * n);
      #1 chk($sformatf("reset_word_%0d", n), read_data, 64'd0);
    end

    // Release reset with the write held: first edge performs it.
    @(negedge clk);
    address = 64'd8; write_data = 64'd5; write_en = 1'b1; read_en = 1'b1;
    rstn = 1'b1;
    #1 chk("post_reset_pre_edge", read_data, 64'd0);
    @(posedge clk); #1;
    chk("post_reset_first_write", read_data, 64'd5);

    // Fill word n with 3n+1, then read back.
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      write_en = 1'b1; read_en = 1'b0; address = 64'(8 * n); write_data = 64'(3 * n + 1);
    end
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      write_en = 1'b0; read_en = 1'b1; address = 64'(8 * n);
      #1 chk($sformatf("fill_word_%0d", n), read_data, 64'(3 * n + 1));
    end

    // Vector table: read_data before the edge, then after it with the same inputs.
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      write_en = vecs[v].we; read_en = vecs[v].re;
      address = vecs[v].addr; write_data = vecs[v].wdata;
      #1 chk({vecs[v].name, "_pre"}, read_data, vecs[v].exp_pre);
      @(posedge clk); #1;
      chk({vecs[v].name, "_post"}, read_data, vecs[v].exp_post);
    end

    // Address 1024 is one past the last word.
    @(negedge clk);
    write_en = 1'b1; read_en = 1'b1; address = 64'd1024; write_data = 64'd7;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    #1 chk("oor_read_pre", read_data, 64'd0);
    @(posedge clk); #1;
    chk("oor_read_post", read_data, 64'd0);
    @(negedge clk);
    write_en = 1'b0; address = 64'd0;
    #1 chk("oor_word0_kept", read_data, 64'hDEAD_BEEF_0000_0001);
`else
    #1 chk("wrap_read_pre", read_data, 64'hDEAD_BEEF_0000_0001);
    @(posedge clk); #1;
    chk("wrap_read_post", read_data, 64'd7);
    @(negedge clk);
    write_en = 1'b0; address = 64'd0;
    #1 chk("wrap_word0", read_data, 64'd7);
`endif

    // Short reset pulse between edges clears the array with no clock edge.
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b1; address = 64'd16;
    #1 chk("pre_pulse_word2", read_data, 64'hA5);
    rstn = 1'b0;
    #1 rstn = 1'b1;
    #0.1 chk("pulse_word2", read_data, 64'd0);
    address = 64'd8;
    #0.5 chk("pulse_word1", read_data, 64'd0);
    address = 64'h3F8;
    #0.5 chk("pulse_word127", read_data, 64'd0);
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      address = 64'(8 * n);
      #1 chk($sformatf("pulse_clear_word_%0d", n), read_data, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
